// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core memory path: funct3 access sizes and
// the data-memory sweep/ready state encoding.
package riscv_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/riscv_dmem_load_ext.sv
// Load extraction: picks the addressed byte/half out of a word and sign/zero extends it.
// Purely combinational, zero latency; no flow control.
module dmem_load_ext
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  size,
  output logic [31:0] data,
  output logic        size_ok
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  // Halves are only meaningful at even lanes; lane[0] is ignored here.
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    data    = '0;
    size_ok = 1'b1;
    case (size)
      MEM_B:   data = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  data = {24'd0, byte_sel};
      MEM_H:   data = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  data = {16'd0, half_sel};
      MEM_W:   data = word;
      default: size_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_dmem.sv
// Data memory behind the M stage: combinational loads, byte-lane stores on the clock edge,
// post-reset clearing sweep (busy) and sticky first-fault capture. Never stalls the core.
module riscv_dmem
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteM,
  input  logic        memreadM,
  input  logic [2:0]  memsizeM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        busy,
  output logic        fault,
  output logic [31:0] fault_addr
);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word;
  logic [31:0]      ext_data;
  logic             size_ok;
  logic             misaligned;
  logic             st_size_bad;
  logic             illegal;
  logic             st_en;

  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [3:0]       mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdata;

  // Address bits above the array size alias and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^aluoutM[31:IDX_W+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DEPTH_WORDS - 1)) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign word_idx = aluoutM[IDX_W+1:2];
  assign lane     = aluoutM[1:0];
  assign rd_word  = mem[word_idx];

  dmem_load_ext u_load_ext (
    .word    (rd_word),
    .lane    (lane),
    .size    (memsizeM),
    .data    (ext_data),
    .size_ok (size_ok)
  );

  assign misaligned  = (((memsizeM == MEM_H) || (memsizeM == MEM_HU)) && lane[0])
                     || ((memsizeM == MEM_W) && (lane != 2'd0));
  assign st_size_bad = memwriteM && ((memsizeM == MEM_BU) || (memsizeM == MEM_HU));
  assign illegal     = (memwriteM || memreadM) && (!size_ok || st_size_bad || misaligned);

  // An unrecognised size reads as zero even with no access qualifier.
  assign readdataM = (busy || illegal || !size_ok) ? 32'd0 : ext_data;

  assign st_en = memwriteM && !illegal && !busy && !reset;

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = writedataM;
    case (memsizeM)
      MEM_B: begin
        st_be    = 4'b0001 << lane;
        st_wdata = {4{writedataM[7:0]}};
      end
      MEM_H: begin
        st_be    = lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{writedataM[15:0]}};
      end
      MEM_W:   st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  // Single write port shared between the clearing sweep and core stores.
  always_comb begin
    mem_we    = 4'b0000;
    mem_widx  = word_idx;
    mem_wdata = st_wdata;
    if (busy && !reset) begin
      mem_we    = 4'b1111;
      mem_widx  = idx_q;
      mem_wdata = 32'd0;
    end else if (st_en) begin
      mem_we = st_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b]) mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_addr <= 32'd0;
    end else if (!busy && illegal && !fault) begin
      fault      <= 1'b1;
      fault_addr <= aluoutM;
    end
  end

endmodule

// File: tb/tb_riscv_dmem.sv
// Self-checking bench for riscv_dmem: directed steps plus randomized accesses
// compared against a byte-array reference model.
module tb_riscv_dmem;

  logic        clk;
  logic        reset;
  logic        memwriteM;
  logic        memreadM;
  logic [2:0]  memsizeM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        busy;
  logic        fault;
  logic [31:0] fault_addr;

  int errors = 0;
  int checks = 0;

  int          mb [4096];
  logic        m_fault;
  logic [31:0] m_faddr;

  riscv_dmem #(.DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwriteM  (memwriteM),
    .memreadM   (memreadM),
    .memsizeM   (memsizeM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .busy       (busy),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_size_legal(input logic [2:0] sz);
    return (sz == 3'd0) || (sz == 3'd1) || (sz == 3'd2) || (sz == 3'd4) || (sz == 3'd5);
  endfunction

  function automatic bit m_illegal(input bit we, input bit re, input logic [2:0] sz, input int a);
    bit bad;
    bad = !m_size_legal(sz) || (we && (sz == 3'd4 || sz == 3'd5));
    if ((sz == 3'd1 || sz == 3'd5) && (a % 2 != 0)) bad = 1;
    if (sz == 3'd2 && (a % 4 != 0)) bad = 1;
    return (we || re) && bad;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input int a);
    int base;
    int v;
    base = a - (a % 4);
    v = 0;
    case (sz)
      3'd0: begin v = mb[a]; if (v >= 128) v = v - 256; end
      3'd4: v = mb[a];
      3'd1: begin v = mb[a] + 256 * mb[a+1]; if (v >= 32768) v = v - 65536; end
      3'd5: v = mb[a] + 256 * mb[a+1];
      3'd2: v = mb[base] + 256 * mb[base+1] + 65536 * mb[base+2] + 16777216 * mb[base+3];
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // One core cycle: drive, check outputs for this cycle, then advance the model across the edge.
  task automatic access(input string tag, input bit we, input bit re, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd);
    int a;
    logic [31:0] exp;
    bit ill;
    a = int'(addr & 32'hFFF);
    @(negedge clk);
    memwriteM  = we;
    memreadM   = re;
    memsizeM   = sz;
    aluoutM    = addr;
    writedataM = wd;
    #1;
    ill = m_illegal(we, re, sz, a);
    exp = (ill || !m_size_legal(sz)) ? 32'd0 : m_load(sz, a);
    chk({tag, ".rdata"}, readdataM, exp);
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, m_fault});
    chk({tag, ".faddr"}, fault_addr, m_faddr);
    if (we && !ill) begin
      case (sz)
        3'd0: mb[a] = int'(wd[7:0]);
        3'd1: begin mb[a] = int'(wd[7:0]); mb[a+1] = int'(wd[15:8]); end
        3'd2: for (int k = 0; k < 4; k++) mb[a+k] = int'((wd >> (8*k)) & 32'hFF);
        default: ;
      endcase
    end
    if (ill && !m_fault) begin
      m_fault = 1'b1;
      m_faddr = addr;
    end
    @(posedge clk);
    #1;
    memwriteM = 1'b0;
    memreadM  = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) mb[i] = 0;
    m_fault = 1'b0;
    m_faddr = 32'd0;
  endtask

  // Counts rising edges until busy drops; called just after reset release.
  task automatic measure_sweep(input string tag, input int already);
    int n;
    n = already;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      if (busy !== 1'b1) break;
    end
    chk(tag, 32'(n), 32'd1024);
  endtask

  initial begin
    bit          rwe, rre;
    logic [2:0]  rsz;
    logic [31:0] raddr, rwd;
    int          n;

    reset = 1'b1; memwriteM = 1'b0; memreadM = 1'b0;
    memsizeM = 3'd2; aluoutM = 32'd0; writedataM = 32'd0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd1);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.faddr", fault_addr, 32'd0);
    chk("rst.rdata", readdataM, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    measure_sweep("sweep1.edges", 0);

    access("lw0", 0, 1, 3'd2, 32'h0, 0);
    access("lwffc", 0, 1, 3'd2, 32'hFFC, 0);

    access("sw10", 1, 0, 3'd2, 32'h10, 32'h80FF7F01);
    access("lb10", 0, 1, 3'd0, 32'h10, 0);
    chk("lb10.const", readdataM, 32'h00000001);
    access("lb13", 0, 1, 3'd0, 32'h13, 0);
    chk("lb13.const", readdataM, 32'hFFFFFF80);
    access("lbu13", 0, 1, 3'd4, 32'h13, 0);
    chk("lbu13.const", readdataM, 32'h00000080);
    access("lh12", 0, 1, 3'd1, 32'h12, 0);
    chk("lh12.const", readdataM, 32'hFFFF80FF);
    access("lhu12", 0, 1, 3'd5, 32'h12, 0);
    chk("lhu12.const", readdataM, 32'h000080FF);

    access("sw20", 1, 0, 3'd2, 32'h20, 32'h11223344);
    access("sb21", 1, 0, 3'd0, 32'h21, 32'h000000AB);
    access("lw20a", 0, 1, 3'd2, 32'h20, 0);
    chk("lw20a.const", readdataM, 32'h1122AB44);
    access("sh22", 1, 0, 3'd1, 32'h22, 32'h0000BEEF);
    access("lw20b", 0, 1, 3'd2, 32'h20, 0);
    chk("lw20b.const", readdataM, 32'hBEEFAB44);

    access("alias_sw", 1, 0, 3'd2, 32'h1000, 32'hCAFEF00D);
    access("alias_lw", 0, 1, 3'd2, 32'h0000, 0);
    chk("alias_lw.const", readdataM, 32'hCAFEF00D);

    access("sw06", 1, 0, 3'd2, 32'h06, 32'hDEADBEEF);
    access("lw04", 0, 1, 3'd2, 32'h04, 0);
    chk("lw04.fault", {31'd0, fault}, 32'd1);
    chk("lw04.faddr", fault_addr, 32'h06);
    chk("lw04.unchanged", readdataM, 32'd0);
    access("lh03", 0, 1, 3'd1, 32'h03, 0);
    access("sbu30", 1, 0, 3'd4, 32'h30, 32'h000000FF);
    access("lw30", 0, 1, 3'd2, 32'h30, 0);
    chk("lw30.faddr", fault_addr, 32'h06);
    access("noacc_bad", 0, 0, 3'd7, 32'h20, 0);
    access("rw_same", 1, 1, 3'd2, 32'h20, 32'h01020304);
    access("rw_after", 0, 1, 3'd2, 32'h20, 0);

    for (int i = 0; i < 300; i++) begin
      rwe   = ($urandom_range(0, 2) == 0);
      rre   = ($urandom_range(0, 1) == 1);
      rsz   = 3'($urandom_range(0, 7));
      raddr = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 63));
      rwd   = $urandom;
      if (!rwe && !rre) begin
        if (rsz == 3'd2) raddr = raddr & ~32'h3;
        if (rsz == 3'd1 || rsz == 3'd5) raddr = raddr & ~32'h1;
      end
      access("rand", rwe, rre, rsz, raddr, rwd);
    end

    // Reset in the middle of a sweep, with a store attempted while busy.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n = 0;
    repeat (5) begin @(posedge clk); n++; end
    @(negedge clk);
    memwriteM = 1'b1; memreadM = 1'b1; memsizeM = 3'd2;
    aluoutM = 32'h0; writedataM = 32'h12345678;
    #1;
    chk("busy.rdata", readdataM, 32'd0);
    @(posedge clk); n++;
    #1;
    memwriteM = 1'b0; memreadM = 1'b0;
    while (n < 500) begin @(posedge clk); n++; end
    #1;
    chk("mid.busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid.rst.busy", {31'd0, busy}, 32'd1);
    chk("mid.rst.fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    measure_sweep("sweep2.edges", 0);
    access("after_busy_lw0", 0, 1, 3'd2, 32'h0, 0);
    chk("after_busy_lw0.const", readdataM, 32'd0);
    access("after_busy_lw10", 0, 1, 3'd2, 32'h10, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
